// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring
// divider sharing one 64-bit working register, fixed 34-cycle issue spacing.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] Result,
  output logic            done,
  output logic            busy,
  output logic            Stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [5:0]        count;
  logic [2*XLEN-1:0] work;
  logic [2*XLEN-1:0] work_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   operand_b;
  logic [2:0]        op;
  logic              neg_res;
  logic              div_zero;

  logic              a_signed, b_signed, neg_a, neg_b, sign_sel;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     sum, diff;
  logic [XLEN-1:0]   quot, rem, result_calc;

  assign Stall = (start && state == IDLE) || state == RUN;

  // Operand conditioning at acceptance time
  always_comb begin
    a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    neg_a    = a_signed && SrcA[XLEN-1];
    neg_b    = b_signed && SrcB[XLEN-1];
    abs_a    = neg_a ? -SrcA : SrcA;
    abs_b    = neg_b ? -SrcB : SrcB;
    sign_sel = neg_a ^ neg_b;
    if (Funct3 == 3'b110)
      sign_sel = neg_a;
    else if (Funct3 == 3'b101 || Funct3 == 3'b111)
      sign_sel = 1'b0;
  end

  // One iteration: shift-add for multiply, shift/trial-subtract for divide
  always_comb begin
    sum       = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, operand_b};
    diff      = work[2*XLEN-1:XLEN-1] - {1'b0, operand_b};
    work_step = work;
    if (op[2]) begin
      if (!diff[XLEN])
        work_step = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
      else
        work_step = {work[2*XLEN-2:0], 1'b0};
    end else if (work[0]) begin
      work_step = {sum, work[XLEN-1:1]};
    end else begin
      work_step = {1'b0, work[2*XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -work_step : work_step;
    quot     = work_step[XLEN-1:0];
    rem      = work_step[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 result_calc = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_calc = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_calc = div_zero ? '1 : (neg_res ? -quot : quot);
      default:                result_calc = neg_res ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      work      <= '0;
      operand_b <= '0;
      op        <= '0;
      neg_res   <= 1'b0;
      div_zero  <= 1'b0;
      Result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op        <= Funct3;
            neg_res   <= sign_sel;
            div_zero  <= (SrcB == '0);
            operand_b <= Funct3[2] ? abs_b : abs_a;
            work      <= {{XLEN{1'b0}}, (Funct3[2] ? abs_a : abs_b)};
            count     <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          work  <= work_step;
          count <= count + 6'd1;
          if (count == 6'(XLEN - 1)) begin
            Result <= result_calc;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, cycle-exact directed sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB, Result;
  logic        done, busy, Stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Result(Result), .done(done), .busy(busy), .Stall(Stall)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // RV32M semantics computed with wide signed/unsigned arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    logic [63:0]     pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
      3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); pv = p; return pv[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; pv = up; return pv[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; pv = p; return pv[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; pv = p; return pv[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a falling edge with the unit idle; returns at the falling edge of the idle cycle after done
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = Result;
    $display("op f3=%0d a=%h b=%h result=%h latency=%0d", f3, a, b, res, lat);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  f3;
    int          lat;

    reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    chk("reset Result", Result, 32'h0);
    chkb("reset done", done, 1'b0);
    chkb("reset busy", busy, 1'b0);
    chkb("reset Stall", Stall, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    vt[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vt[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[3]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vt[6]  = '{3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
    vt[7]  = '{3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001};
    vt[8]  = '{3'd5, 32'd100,      32'd0,        32'hFFFFFFFF};
    vt[9]  = '{3'd6, 32'd100,      32'd0,        32'd100};
    vt[10] = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vt[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vt[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vt[13] = '{3'd0, 32'd7,        32'd6,        32'd42};

    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].f3, vt[i].a, vt[i].b, res, lat);
      chk($sformatf("vec%0d result", i), res, vt[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
    end

    // MUL 7x6 cycle by cycle, with ignored start pulses in RUN (cycle 5) and DONE (cycle 33)
    Funct3 = 3'd0; SrcA = 32'd7; SrcB = 32'd6; start = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      #1;
      chkb($sformatf("mul Stall c%0d", c), Stall, c <= 32);
      chkb($sformatf("mul done c%0d", c), done, c == 33);
      chkb($sformatf("mul busy c%0d", c), busy, c >= 1 && c <= 33);
      if (c == 33) chk("mul 7x6", Result, 32'd42);
      @(negedge clk);
      start = (c + 1 == 5) || (c + 1 == 33);
      Funct3 = 3'd5; SrcA = $urandom; SrcB = $urandom;
    end
    $display("op f3=0 a=00000007 b=00000006 result=%h (timed)", Result);

    // Flush in RUN cycle 10
    Funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456; start = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      #1;
      chkb($sformatf("flush done c%0d", c), done, 1'b0);
      if (c >= 11) begin
        chkb($sformatf("flush busy c%0d", c), busy, 1'b0);
        chkb($sformatf("flush Stall c%0d", c), Stall, 1'b0);
        chk($sformatf("flush Result c%0d", c), Result, 32'd42);
      end
      @(negedge clk);
      start = 1'b0;
      flush = (c + 1 == 10);
    end
    $display("op flushed in RUN cycle 10, Result held %h", Result);
    do_op(3'd0, 32'd3, 32'd5, res, lat);
    chk("after flush 3x5", res, 32'd15);
    chk("after flush latency", 32'(lat), 32'd33);

    // Reset in RUN cycle 10
    Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7; start = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      #1;
      chkb($sformatf("rst done c%0d", c), done, 1'b0);
      if (c >= 11) begin
        chkb($sformatf("rst busy c%0d", c), busy, 1'b0);
        chkb($sformatf("rst Stall c%0d", c), Stall, 1'b0);
        chk($sformatf("rst Result c%0d", c), Result, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      reset = (c + 1 == 10);
    end
    $display("op reset in RUN cycle 10, Result %h", Result);
    do_op(3'd0, 32'd3, 32'd5, res, lat);
    chk("after reset 3x5", res, 32'd15);
    chk("after reset latency", 32'(lat), 32'd33);

    // Back-to-back: DIVU then REMU accepted in cycle 34
    Funct3 = 3'd5; SrcA = 32'hFFFFFFFF; SrcB = 32'd16; start = 1'b1;
    for (int c = 0; c <= 68; c++) begin
      #1;
      chkb($sformatf("b2b done c%0d", c), done, c == 33 || c == 67);
      if (c >= 33 && c <= 66) chk($sformatf("b2b divu c%0d", c), Result, 32'h0FFFFFFF);
      if (c == 67) chk("b2b remu", Result, 32'd15);
      @(negedge clk);
      start = (c + 1 == 34);
      if (start) begin
        Funct3 = 3'd7; SrcA = 32'hFFFFFFFF; SrcB = 32'd16;
      end else begin
        Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      end
    end
    $display("op back-to-back divu/remu final result=%h", Result);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(f3, a, b, res, lat);
      chk($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), res, ref_op(f3, a, b));
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'd33);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
